// File: rtl/ahb_pkg.sv
// Shared AHB encodings and arbiter types for the two-master memory arbiter.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef logic mst_idx_t;
  localparam mst_idx_t MST_M0 = 1'b0;
  localparam mst_idx_t MST_M1 = 1'b1;

  typedef enum logic {ST_EMPTY = 1'b0, ST_PENDING = 1'b1} stage_state_t;

endpackage

// File: rtl/ahb_input_stage.sv
// Per-master holding stage: parks an address phase that lost arbitration or
// arrived while the slave was stalled, until it is granted.
module ahb_input_stage
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  req,
  input  logic                  grant,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  output logic                  pending,
  output logic [ADDR_WIDTH-1:0] haddr_q,
  output logic [1:0]            htrans_q,
  output logic                  hwrite_q,
  output logic [2:0]            hsize_q
);

  stage_state_t          state_p1;
  logic                  capture;
  logic [ADDR_WIDTH-1:0] haddr_p1;
  logic [1:0]            htrans_p1;
  logic                  hwrite_p1;
  logic [2:0]            hsize_p1;

  assign capture = (state_p1 == ST_EMPTY) && req && !grant;

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_p1 <= ST_EMPTY;
    end else begin
      case (state_p1)
        ST_EMPTY:   if (capture) state_p1 <= ST_PENDING;
        ST_PENDING: if (grant)   state_p1 <= ST_EMPTY;
        default:                 state_p1 <= ST_EMPTY;
      endcase
    end
  end

  // Address-phase payload is only meaningful while PENDING, so it is not reset.
  always_ff @(posedge HCLK) begin
    if (capture) begin
      haddr_p1  <= haddr;
      htrans_p1 <= htrans;
      hwrite_p1 <= hwrite;
      hsize_p1  <= hsize;
    end
  end

  assign pending  = (state_p1 == ST_PENDING);
  assign haddr_q  = haddr_p1;
  assign htrans_q = htrans_p1;
  assign hwrite_q = hwrite_p1;
  assign hsize_q  = hsize_p1;

endmodule

// File: rtl/ahb_mem_arbiter.sv
// Two-master AHB arbiter in front of a single memory slave: zero-latency grant
// when uncontended, round-robin with one-deep holding stages when contended.
module ahb_mem_arbiter
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_WIDTH-1:0] HADDR_M0,
  input  logic [1:0]            HTRANS_M0,
  input  logic                  HWRITE_M0,
  input  logic [2:0]            HSIZE_M0,
  input  logic [DATA_WIDTH-1:0] HWDATA_M0,
  output logic                  HREADY_M0,
  output logic [DATA_WIDTH-1:0] HRDATA_M0,
  input  logic [ADDR_WIDTH-1:0] HADDR_M1,
  input  logic [1:0]            HTRANS_M1,
  input  logic                  HWRITE_M1,
  input  logic [2:0]            HSIZE_M1,
  input  logic [DATA_WIDTH-1:0] HWDATA_M1,
  output logic                  HREADY_M1,
  output logic [DATA_WIDTH-1:0] HRDATA_M1,
  output logic                  HSEL_S,
  output logic [ADDR_WIDTH-1:0] HADDR_S,
  output logic [1:0]            HTRANS_S,
  output logic                  HWRITE_S,
  output logic [2:0]            HSIZE_S,
  output logic [DATA_WIDTH-1:0] HWDATA_S,
  output logic                  HREADY_S,
  input  logic                  HREADYOUT_S,
  input  logic [DATA_WIDTH-1:0] HRDATA_S
);

  logic                  req0, req1, pend0, pend1, cand0, cand1;
  logic                  grant_en, gnt_vld, contended;
  mst_idx_t              gnt_idx, rr_ptr;
  logic                  own_vld_p1;
  mst_idx_t              own_idx_p1;
  logic [ADDR_WIDTH-1:0] haddr_s_p1;
  logic [ADDR_WIDTH-1:0] h_addr0, h_addr1, sel_addr;
  logic [1:0]            h_trans0, h_trans1, sel_trans;
  logic                  h_write0, h_write1, sel_write;
  logic [2:0]            h_size0, h_size1, sel_size;

  assign req0 = HTRANS_M0[1] && HREADY_M0;
  assign req1 = HTRANS_M1[1] && HREADY_M1;

  ahb_input_stage #(.ADDR_WIDTH(ADDR_WIDTH)) u_stage_m0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req0),
    .grant(gnt_vld && (gnt_idx == MST_M0)),
    .haddr(HADDR_M0), .htrans(HTRANS_M0), .hwrite(HWRITE_M0), .hsize(HSIZE_M0),
    .pending(pend0), .haddr_q(h_addr0), .htrans_q(h_trans0),
    .hwrite_q(h_write0), .hsize_q(h_size0)
  );

  ahb_input_stage #(.ADDR_WIDTH(ADDR_WIDTH)) u_stage_m1 (
    .HCLK(HCLK), .HRESETn(HRESETn), .req(req1),
    .grant(gnt_vld && (gnt_idx == MST_M1)),
    .haddr(HADDR_M1), .htrans(HTRANS_M1), .hwrite(HWRITE_M1), .hsize(HSIZE_M1),
    .pending(pend1), .haddr_q(h_addr1), .htrans_q(h_trans1),
    .hwrite_q(h_write1), .hsize_q(h_size1)
  );

  assign cand0     = pend0 || req0;
  assign cand1     = pend1 || req1;
  assign contended = cand0 && cand1;
  // Holding reset low also blocks grants so a parked transfer cannot leak out.
  assign grant_en  = HRESETn && HREADYOUT_S;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = MST_M0;
    if (grant_en) begin
      if (pend0 && !pend1) begin
        gnt_vld = 1'b1;
        gnt_idx = MST_M0;
      end else if (pend1 && !pend0) begin
        gnt_vld = 1'b1;
        gnt_idx = MST_M1;
      end else if (contended) begin
        gnt_vld = 1'b1;
        gnt_idx = rr_ptr;
      end else if (cand0 || cand1) begin
        gnt_vld = 1'b1;
        gnt_idx = cand1 ? MST_M1 : MST_M0;
      end
    end
  end

  always_comb begin
    if (gnt_idx == MST_M1) begin
      sel_addr  = pend1 ? h_addr1  : HADDR_M1;
      sel_trans = pend1 ? h_trans1 : HTRANS_M1;
      sel_write = pend1 ? h_write1 : HWRITE_M1;
      sel_size  = pend1 ? h_size1  : HSIZE_M1;
    end else begin
      sel_addr  = pend0 ? h_addr0  : HADDR_M0;
      sel_trans = pend0 ? h_trans0 : HTRANS_M0;
      sel_write = pend0 ? h_write0 : HWRITE_M0;
      sel_size  = pend0 ? h_size0  : HSIZE_M0;
    end
  end

  // Arbitration stage -> data-phase stage
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rr_ptr     <= MST_M0;
      own_vld_p1 <= 1'b0;
      own_idx_p1 <= MST_M0;
      haddr_s_p1 <= '0;
    end else begin
      if (grant_en && contended) rr_ptr <= ~gnt_idx;
      if (HREADYOUT_S) begin
        own_vld_p1 <= gnt_vld;
        own_idx_p1 <= gnt_idx;
      end
      if (gnt_vld) haddr_s_p1 <= sel_addr;
    end
  end

  assign HSEL_S   = gnt_vld;
  assign HADDR_S  = gnt_vld ? sel_addr  : haddr_s_p1;
  assign HTRANS_S = gnt_vld ? sel_trans : HTRANS_IDLE;
  assign HWRITE_S = gnt_vld ? sel_write : 1'b0;
  assign HSIZE_S  = gnt_vld ? sel_size  : 3'b000;
  assign HWDATA_S = !own_vld_p1 ? '0 : (own_idx_p1 == MST_M1) ? HWDATA_M1 : HWDATA_M0;
  assign HREADY_S = HREADYOUT_S;

  assign HREADY_M0 = pend0 ? 1'b0 :
                     (own_vld_p1 && own_idx_p1 == MST_M0) ? HREADYOUT_S : 1'b1;
  assign HREADY_M1 = pend1 ? 1'b0 :
                     (own_vld_p1 && own_idx_p1 == MST_M1) ? HREADYOUT_S : 1'b1;

  assign HRDATA_M0 = HRDATA_S;
  assign HRDATA_M1 = HRDATA_S;

endmodule

// File: tb/tb_ahb_mem_arbiter.sv
// Directed bench for ahb_mem_arbiter with a small word-addressed memory slave.
module tb_ahb_mem_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR_M0, HADDR_M1, HWDATA_M0, HWDATA_M1;
  logic [1:0]  HTRANS_M0, HTRANS_M1;
  logic        HWRITE_M0, HWRITE_M1;
  logic [2:0]  HSIZE_M0, HSIZE_M1;
  logic        HREADY_M0, HREADY_M1;
  logic [31:0] HRDATA_M0, HRDATA_M1;
  logic        HSEL_S, HWRITE_S, HREADY_S, HREADYOUT_S;
  logic [31:0] HADDR_S, HWDATA_S, HRDATA_S;
  logic [1:0]  HTRANS_S;
  logic [2:0]  HSIZE_S;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  ahb_mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .HADDR_M0(HADDR_M0), .HTRANS_M0(HTRANS_M0), .HWRITE_M0(HWRITE_M0),
    .HSIZE_M0(HSIZE_M0), .HWDATA_M0(HWDATA_M0), .HREADY_M0(HREADY_M0),
    .HRDATA_M0(HRDATA_M0),
    .HADDR_M1(HADDR_M1), .HTRANS_M1(HTRANS_M1), .HWRITE_M1(HWRITE_M1),
    .HSIZE_M1(HSIZE_M1), .HWDATA_M1(HWDATA_M1), .HREADY_M1(HREADY_M1),
    .HRDATA_M1(HRDATA_M1),
    .HSEL_S(HSEL_S), .HADDR_S(HADDR_S), .HTRANS_S(HTRANS_S), .HWRITE_S(HWRITE_S),
    .HSIZE_S(HSIZE_S), .HWDATA_S(HWDATA_S), .HREADY_S(HREADY_S),
    .HREADYOUT_S(HREADYOUT_S), .HRDATA_S(HRDATA_S)
  );

  // Memory slave: captures address phase, writes/reads in the data phase.
  logic        dp_vld, dp_wr;
  logic [31:0] dp_addr;
  logic [31:0] mem [0:63];

  always @(posedge HCLK) begin
    if (!HRESETn) begin
      dp_vld <= 1'b0;
    end else if (HREADY_S) begin
      if (dp_vld && dp_wr) mem[dp_addr[7:2]] <= HWDATA_S;
      dp_vld  <= HSEL_S && HTRANS_S[1];
      dp_addr <= HADDR_S;
      dp_wr   <= HWRITE_S;
    end
  end

  assign HRDATA_S = dp_vld ? mem[dp_addr[7:2]] : 32'h0;

  task automatic next_cycle();
    @(posedge HCLK);
    #1;
  endtask

  task automatic idle_masters();
    HTRANS_M0 = 2'b00; HADDR_M0 = 32'h0; HWRITE_M0 = 1'b0; HSIZE_M0 = 3'b010;
    HTRANS_M1 = 2'b00; HADDR_M1 = 32'h0; HWRITE_M1 = 1'b0; HSIZE_M1 = 3'b010;
  endtask

  task automatic do_reset();
    HRESETn = 1'b0;
    HREADYOUT_S = 1'b1;
    HWDATA_M0 = 32'h0; HWDATA_M1 = 32'h0;
    idle_masters();
    next_cycle();
    next_cycle();
    HRESETn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge HCLK);
    checks++; if (HREADY_M0 !== 1'b1) begin errors++; $display("FAIL rst_hready_m0: got %b want 1", HREADY_M0); end
    checks++; if (HREADY_M1 !== 1'b1) begin errors++; $display("FAIL rst_hready_m1: got %b want 1", HREADY_M1); end
    checks++; if (HSEL_S !== 1'b0) begin errors++; $display("FAIL rst_hsel: got %b want 0", HSEL_S); end
    checks++; if (HTRANS_S !== 2'b00) begin errors++; $display("FAIL rst_htrans: got %b want 00", HTRANS_S); end
    checks++; if (HADDR_S !== 32'h0) begin errors++; $display("FAIL rst_haddr: got %h want 0", HADDR_S); end
    checks++; if (HWDATA_S !== 32'h0) begin errors++; $display("FAIL rst_hwdata: got %h want 0", HWDATA_S); end
  endtask

  task automatic test_uncontended();
    do_reset();
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h100; HWRITE_M0 = 1'b1;
    @(negedge HCLK);
    checks++; if (HSEL_S !== 1'b1 || HADDR_S !== 32'h100 || HWRITE_S !== 1'b1)
      begin errors++; $display("FAIL unc_wr_addr: got sel=%b addr=%h wr=%b want 1/100/1", HSEL_S, HADDR_S, HWRITE_S); end
    checks++; if (HREADY_M0 !== 1'b1) begin errors++; $display("FAIL unc_rdy_a: got %b want 1", HREADY_M0); end
    next_cycle();
    HWDATA_M0 = 32'hDEADBEEF; HTRANS_M0 = 2'b10; HADDR_M0 = 32'h100; HWRITE_M0 = 1'b0;
    @(negedge HCLK);
    checks++; if (HWDATA_S !== 32'hDEADBEEF) begin errors++; $display("FAIL unc_hwdata: got %h want deadbeef", HWDATA_S); end
    checks++; if (HSEL_S !== 1'b1 || HWRITE_S !== 1'b0 || HADDR_S !== 32'h100)
      begin errors++; $display("FAIL unc_rd_addr: got sel=%b wr=%b addr=%h want 1/0/100", HSEL_S, HWRITE_S, HADDR_S); end
    checks++; if (HREADY_M0 !== 1'b1) begin errors++; $display("FAIL unc_rdy_b: got %b want 1", HREADY_M0); end
    next_cycle();
    idle_masters();
    @(negedge HCLK);
    checks++; if (HRDATA_M0 !== 32'hDEADBEEF) begin errors++; $display("FAIL unc_rdata: got %h want deadbeef", HRDATA_M0); end
    checks++; if (HRDATA_M1 !== 32'hDEADBEEF) begin errors++; $display("FAIL unc_rdata_m1: got %h want deadbeef", HRDATA_M1); end
    checks++; if (HREADY_M0 !== 1'b1 || HSEL_S !== 1'b0)
      begin errors++; $display("FAIL unc_end: got rdy=%b sel=%b want 1/0", HREADY_M0, HSEL_S); end
  endtask

  task automatic test_contended();
    do_reset();
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h0;
    HTRANS_M1 = 2'b10; HADDR_M1 = 32'h4;
    @(negedge HCLK);
    checks++; if (HSEL_S !== 1'b1 || HADDR_S !== 32'h0)
      begin errors++; $display("FAIL con_first: got sel=%b addr=%h want 1/0", HSEL_S, HADDR_S); end
    checks++; if (HREADY_M1 !== 1'b1) begin errors++; $display("FAIL con_rdy_m1_a: got %b want 1", HREADY_M1); end
    next_cycle();
    idle_masters();
    @(negedge HCLK);
    checks++; if (HREADY_M1 !== 1'b0) begin errors++; $display("FAIL con_rdy_m1_b: got %b want 0", HREADY_M1); end
    checks++; if (HSEL_S !== 1'b1 || HADDR_S !== 32'h4 || HTRANS_S !== 2'b10)
      begin errors++; $display("FAIL con_second: got sel=%b addr=%h trans=%b want 1/4/10", HSEL_S, HADDR_S, HTRANS_S); end
    checks++; if (HREADY_M0 !== 1'b1) begin errors++; $display("FAIL con_rdy_m0_b: got %b want 1", HREADY_M0); end
    next_cycle();
    @(negedge HCLK);
    checks++; if (HREADY_M1 !== 1'b1 || HSEL_S !== 1'b0 || HADDR_S !== 32'h4)
      begin errors++; $display("FAIL con_end: got rdy=%b sel=%b addr=%h want 1/0/4", HREADY_M1, HSEL_S, HADDR_S); end
  endtask

  task automatic test_alternate();
    logic [31:0] exp_addr [6];
    exp_addr = '{32'h10, 32'h20, 32'h10, 32'h20, 32'h10, 32'h20};
    do_reset();
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h10;
    HTRANS_M1 = 2'b10; HADDR_M1 = 32'h20;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      checks++; if (HSEL_S !== 1'b1 || HADDR_S !== exp_addr[i])
        begin errors++; $display("FAIL alt_grant[%0d]: got sel=%b addr=%h want 1/%h", i, HSEL_S, HADDR_S, exp_addr[i]); end
      if (i > 0) begin
        checks++; if (HREADY_M0 === HREADY_M1)
          begin errors++; $display("FAIL alt_stall[%0d]: got rdy0=%b rdy1=%b want exactly one low", i, HREADY_M0, HREADY_M1); end
      end
      next_cycle();
    end
    idle_masters();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      a = 32'h200 + 32'(i * 4);
      HTRANS_M0 = (i == 0) ? 2'b10 : 2'b11; HADDR_M0 = a;
      @(negedge HCLK);
      checks++; if (HSEL_S !== 1'b1 || HADDR_S !== a || HTRANS_S !== HTRANS_M0 || HREADY_M0 !== 1'b1)
        begin errors++; $display("FAIL b2b[%0d]: got sel=%b addr=%h trans=%b rdy=%b want 1/%h/%b/1", i, HSEL_S, HADDR_S, HTRANS_S, HREADY_M0, a, HTRANS_M0); end
      next_cycle();
    end
    idle_masters();
  endtask

  task automatic test_stall();
    do_reset();
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h40; HWRITE_M0 = 1'b1;
    HTRANS_M1 = 2'b10; HADDR_M1 = 32'h44;
    @(negedge HCLK);
    checks++; if (HADDR_S !== 32'h40) begin errors++; $display("FAIL stl_first: got %h want 40", HADDR_S); end
    next_cycle();
    idle_masters();
    HREADYOUT_S = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      checks++; if (HSEL_S !== 1'b0 || HTRANS_S !== 2'b00 || HADDR_S !== 32'h40)
        begin errors++; $display("FAIL stl_hold[%0d]: got sel=%b trans=%b addr=%h want 0/00/40", i, HSEL_S, HTRANS_S, HADDR_S); end
      checks++; if (HREADY_M0 !== 1'b0 || HREADY_M1 !== 1'b0)
        begin errors++; $display("FAIL stl_rdy[%0d]: got rdy0=%b rdy1=%b want 0/0", i, HREADY_M0, HREADY_M1); end
      next_cycle();
    end
    HREADYOUT_S = 1'b1;
    @(negedge HCLK);
    checks++; if (HSEL_S !== 1'b1 || HADDR_S !== 32'h44)
      begin errors++; $display("FAIL stl_release: got sel=%b addr=%h want 1/44", HSEL_S, HADDR_S); end
    checks++; if (HREADY_M0 !== 1'b1) begin errors++; $display("FAIL stl_rdy_m0: got %b want 1", HREADY_M0); end
    next_cycle();
    @(negedge HCLK);
    checks++; if (HREADY_M1 !== 1'b1 || HSEL_S !== 1'b0)
      begin errors++; $display("FAIL stl_end: got rdy1=%b sel=%b want 1/0", HREADY_M1, HSEL_S); end
  endtask

  task automatic test_reset_pending();
    do_reset();
    HTRANS_M0 = 2'b10; HADDR_M0 = 32'h80;
    HTRANS_M1 = 2'b10; HADDR_M1 = 32'h84;
    next_cycle();
    idle_masters();
    HRESETn = 1'b0;
    @(negedge HCLK);
    checks++; if (HSEL_S !== 1'b0) begin errors++; $display("FAIL rp_during: got sel=%b addr=%h want sel 0", HSEL_S, HADDR_S); end
    next_cycle();
    HRESETn = 1'b1;
    @(negedge HCLK);
    checks++; if (HREADY_M0 !== 1'b1 || HREADY_M1 !== 1'b1)
      begin errors++; $display("FAIL rp_rdy: got rdy0=%b rdy1=%b want 1/1", HREADY_M0, HREADY_M1); end
    checks++; if (HTRANS_S !== 2'b00 || HSEL_S !== 1'b0)
      begin errors++; $display("FAIL rp_idle: got trans=%b sel=%b want 00/0", HTRANS_S, HSEL_S); end
    next_cycle();
    @(negedge HCLK);
    checks++; if (HSEL_S !== 1'b0 || HADDR_S !== 32'h0)
      begin errors++; $display("FAIL rp_no_replay: got sel=%b addr=%h want 0/0", HSEL_S, HADDR_S); end
  endtask

  initial begin
    test_reset();
    test_uncontended();
    test_contended();
    test_alternate();
    test_back_to_back();
    test_stall();
    test_reset_pending();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_mem_arbiter.md
AHB_MEM_ARBITER -- requirements
Module: ahb_mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, giving the address bus width on all ports.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, giving the data bus width; only 32 is supported.
REQ-003 The block SHALL have one clock and a synchronous active-low reset.
REQ-004 HCLK  in  1  clock; all state changes on its rising edge.
REQ-005 HRESETn  in  1  synchronous active-low reset.
REQ-006 HADDR_M0/HADDR_M1  in  ADDR_WIDTH  master address.
REQ-007 HTRANS_M0/HTRANS_M1  in  2  master transfer type.
REQ-008 HWRITE_M0/HWRITE_M1  in  1  master write flag.
REQ-009 HSIZE_M0/HSIZE_M1  in  3  master transfer size.
REQ-010 HWDATA_M0/HWDATA_M1  in  DATA_WIDTH  master write data.
REQ-011 HREADY_M0/HREADY_M1  out  1  per-master ready.
REQ-012 HRDATA_M0/HRDATA_M1  out  DATA_WIDTH  read data; both SHALL equal HRDATA_S.
REQ-013 HSEL_S, HADDR_S, HTRANS_S, HWRITE_S, HSIZE_S, HWDATA_S  out  slave address/data-phase signals, with widths as on the master ports.
REQ-014 HREADY_S  out  1  slave HREADY input; SHALL equal HREADYOUT_S.
REQ-015 HREADYOUT_S  in  1  slave ready.
REQ-016 HRDATA_S  in  DATA_WIDTH  slave read data.

Function
REQ-017 A master request SHALL be its HTRANS[1]=1 while its HREADY_Mx=1; IDLE and BUSY transfers SHALL be ignored.
REQ-018 Each master port SHALL hold one input stage with states EMPTY and PENDING.
- EMPTY->PENDING: on a request that is not granted in that cycle; HADDR/HTRANS/HWRITE/HSIZE are captured.
- PENDING->EMPTY: on the grant of the held transfer.
REQ-019 Grant SHALL be issued only in cycles with HREADYOUT_S=1.
REQ-020 A PENDING stage SHALL beat a new request from the other master.
- Two new simultaneous requests: the round-robin pointer decides (reset value M0).
- After a contended grant, the pointer SHALL point to the loser.
REQ-021 The granted master's address-phase signals SHALL drive the slave port combinationally in the grant cycle, with HSEL_S=1.
- These come from the held register if PENDING, else from the live inputs.
- With no grant: HSEL_S=0, HTRANS_S=IDLE (2'b00), and HADDR_S keeps its last value.
REQ-022 A data-phase owner register (valid plus index) SHALL load on every cycle with HREADYOUT_S=1.
- It loads the granted index when a grant occurs; otherwise valid=0.
- HWDATA_S SHALL be muxed from the owner's HWDATA.
REQ-023 HREADY_Mx SHALL be 0 while stage x is PENDING.
- Otherwise, if x owns the data phase, HREADY_Mx=HREADYOUT_S.
- Otherwise HREADY_Mx=1.
REQ-024 Latency: an uncontended transfer SHALL add zero cycles; a contended loser SHALL be granted exactly one cycle later, given HREADYOUT_S=1.
REQ-025 When HREADYOUT_S=0, no grant SHALL occur, and owner, pending stages and pointer SHALL hold.
- New requests still move EMPTY->PENDING.
REQ-026 Back-to-back transfers from one master with no contention SHALL sustain one transfer per cycle.

Reset
REQ-027 With HRESETn=0 at a clock edge, the block SHALL reset as follows:
- Both stages go EMPTY and owner valid=0.
- The pointer is set to M0.
- Outputs: HREADY_M0=HREADY_M1=1, HSEL_S=0, HTRANS_S=IDLE, HADDR_S=0, HWDATA_S=0.
REQ-028 Reset during a PENDING or data phase SHALL discard the transfer, with no replay after reset.

Structure
REQ-029 Package ahb_pkg SHALL hold:
- HTRANS encodings: IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
- HSIZE codes: byte 000, half 001, word 010.
- The master-index type.
- The stage-state type {EMPTY, PENDING}.
REQ-030 Sub-module ahb_input_stage SHALL implement REQ-018 and SHALL be instantiated once per master.

Verification
REQ-031 M0 writes word 0xDEADBEEF to 0x100 uncontended, then reads 0x100 -> M1 stays idle, HREADY_M0 never low, and the read returns 0xDEADBEEF in the next cycle.
REQ-032 M0 and M1 issue NONSEQ in the same cycle, to 0x0 and 0x4 -> M0 granted first; HREADY_M1=0 for one cycle; M1's transfer appears on the slave next cycle.
REQ-033 Both masters issue continuous requests -> grants alternate M0,M1,M0,M1 and neither master starves for more than one cycle.
REQ-034 HREADYOUT_S forced 0 for 3 cycles while M1 is PENDING -> no grant, slave outputs stable, and M1 is granted on the first ready cycle.
REQ-035 HRESETn=0 for one cycle while M1 is PENDING -> next cycle both HREADY are 1, HTRANS_S=IDLE, and the held transfer never reaches the slave.
